// File: rtl/frogger_pkg.sv
// frogger_pkg: shared lane geometry, per-lane motion config record and scheduler states
package frogger_pkg;
    localparam int NUM_LANES = 8;
    localparam int X_W = 10;
    localparam int WRAP = 768;

    typedef struct packed {
        logic       dir;
        logic [3:0] speed;
        logic [3:0] div;
    } lane_cfg_t;

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} lms_state_t;
endpackage

// File: rtl/vs_edge_sync.sv
// vs_edge_sync: brings VGA vertical sync into the Clk domain and flags its rising edge
module vs_edge_sync (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_clk,
    output logic tick
);
    logic [2:0] sync_q;
    logic       tick_q;

    // two synchronizer flops, one history flop, registered rising-edge pulse
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_q <= '0;
            tick_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], frame_clk};
            tick_q <= sync_q[1] & ~sync_q[2];
        end
    end

    assign tick = tick_q;
endmodule

// File: rtl/lane_motion_scheduler.sv
// lane_motion_scheduler: per-frame sweep that steps every obstacle lane through one shared wrap adder
module lane_motion_scheduler
    import frogger_pkg::*;
#(
    parameter int NUM_LANES = frogger_pkg::NUM_LANES,
    parameter int X_W       = frogger_pkg::X_W,
    parameter int WRAP      = frogger_pkg::WRAP
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         frame_clk,
    input  logic                         run,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_LANES)-1:0] cfg_lane,
    input  logic                         cfg_dir,
    input  logic [3:0]                   cfg_speed,
    input  logic [3:0]                   cfg_div,
    input  logic [X_W-1:0]               cfg_x,
    output logic [NUM_LANES*X_W-1:0]     lane_x,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         overrun
);
    localparam int LW = $clog2(NUM_LANES);
    localparam logic [X_W:0] WRAP_W = (X_W+1)'(WRAP);

    lane_cfg_t      cfg_q     [NUM_LANES];
    logic [3:0]     div_cnt_q [NUM_LANES];
    logic [X_W-1:0] x_q       [NUM_LANES];
    lms_state_t     state_q;
    logic [LW-1:0]  idx_q;
    logic           busy_q, frame_done_q, overrun_q;
    logic           tick;

    lane_cfg_t      cur;
    logic [X_W:0]   cur_x, spd, sum;
    logic [X_W-1:0] x_d;
    logic [3:0]     div_cnt_d;
    logic           hit;

    vs_edge_sync u_sync (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    // shared step/wrap datapath for the lane selected by the sweep index
    always_comb begin
        cur       = cfg_q[idx_q];
        cur_x     = {1'b0, x_q[idx_q]};
        spd       = (X_W+1)'(cur.speed);
        sum       = cur_x + spd;
        hit       = div_cnt_q[idx_q] == cur.div;
        div_cnt_d = hit ? 4'd0 : div_cnt_q[idx_q] + 4'd1;
        x_d       = !hit ? x_q[idx_q] :
                    X_W'(cur.dir ? (cur_x < spd ? cur_x + WRAP_W - spd : cur_x - spd)
                                 : (sum >= WRAP_W ? sum - WRAP_W : sum));
    end

    // lane registers: sweep writeback, then config write so it overrides a same-lane step
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                cfg_q[i]     <= '0;
                div_cnt_q[i] <= '0;
                x_q[i]       <= '0;
            end
        end else begin
            if (state_q == SWEEP) begin
                div_cnt_q[idx_q] <= div_cnt_d;
                x_q[idx_q]       <= x_d;
            end
            if (cfg_we) begin
                cfg_q[cfg_lane]     <= {cfg_dir, cfg_speed, cfg_div};
                div_cnt_q[cfg_lane] <= '0;
                x_q[cfg_lane]       <= cfg_x;
            end
        end
    end

    // sweep sequencer with registered status outputs
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            overrun_q    <= tick && state_q != IDLE;
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: if (tick && run) begin
                    state_q <= SWEEP;
                    idx_q   <= '0;
                    busy_q  <= 1'b1;
                end
                SWEEP: begin
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == LW'(NUM_LANES - 1)) begin
                        state_q      <= DONE;
                        frame_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign lane_x[i*X_W +: X_W] = x_q[i];
    end

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;
endmodule

// File: tb/tb_lane_motion_scheduler.sv
// tb_lane_motion_scheduler: directed frames checked every cycle against a frame-level lane model
module tb_lane_motion_scheduler;
    localparam int N  = 8;
    localparam int XW = 10;
    localparam int WR = 768;

    logic          clk = 1'b0;
    logic          Reset_n = 1'b0, frame_clk = 1'b0, run = 1'b0, cfg_we = 1'b0;
    logic [2:0]    cfg_lane = '0;
    logic          cfg_dir = 1'b0;
    logic [3:0]    cfg_speed = '0, cfg_div = '0;
    logic [XW-1:0] cfg_x = '0;
    logic [N*XW-1:0] lane_x;
    logic          busy, frame_done, overrun;

    int checks = 0, failures = 0;
    int mx[N], mspd[N], mdir[N], mdiv[N], mcnt[N];
    int pos = -1;
    bit m_ov = 1'b0, tk_prev = 1'b0;
    bit vsh[$];
    int fd_cnt = 0, ov_cnt = 0, busy_cnt = 0, busy_run = 0, busy_width = 0;

    always #5 clk = ~clk;

    lane_motion_scheduler dut (
        .Clk        (clk),
        .Reset_n    (Reset_n),
        .frame_clk  (frame_clk),
        .run        (run),
        .cfg_we     (cfg_we),
        .cfg_lane   (cfg_lane),
        .cfg_dir    (cfg_dir),
        .cfg_speed  (cfg_speed),
        .cfg_div    (cfg_div),
        .cfg_x      (cfg_x),
        .lane_x     (lane_x),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    task automatic chk_v(input string nm, input logic [N*XW-1:0] act, input logic [N*XW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_b(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int lx(input int k);
        return int'(lane_x[k*XW +: XW]);
    endfunction

    function automatic logic [N*XW-1:0] mvec();
        logic [N*XW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*XW +: XW] = XW'(mx[i]);
        return v;
    endfunction

    // Model: VS edge seen 3 samples late; a frame visits lanes 0..N-1 one per cycle, then a done cycle.
    task automatic model_edge();
        bit tk;
        if (!Reset_n) begin
            for (int i = 0; i < N; i++) begin
                mx[i] = 0; mspd[i] = 0; mdir[i] = 0; mdiv[i] = 0; mcnt[i] = 0;
            end
            pos = -1;
            m_ov = 1'b0;
            tk_prev = 1'b0;
            vsh = {1'b0, 1'b0, 1'b0, 1'b0};
            return;
        end
        tk = tk_prev;
        m_ov = tk && pos != -1;
        if (pos == -1) begin
            if (tk && run) pos = 0;
        end else if (pos < N) begin
            if (mcnt[pos] == mdiv[pos]) begin
                mcnt[pos] = 0;
                mx[pos] = mdir[pos] != 0 ? (mx[pos] - mspd[pos] + WR) % WR : (mx[pos] + mspd[pos]) % WR;
            end else begin
                mcnt[pos]++;
            end
            pos++;
        end else begin
            pos = -1;
        end
        if (cfg_we) begin
            mdir[cfg_lane] = int'(cfg_dir);
            mspd[cfg_lane] = int'(cfg_speed);
            mdiv[cfg_lane] = int'(cfg_div);
            mcnt[cfg_lane] = 0;
            mx[cfg_lane]   = int'(cfg_x);
        end
        vsh.push_back(frame_clk);
        if (vsh.size() > 8) void'(vsh.pop_front());
        tk_prev = vsh[vsh.size()-3] && !vsh[vsh.size()-4];
    endtask

    initial forever begin
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk_v("lane_x", lane_x, mvec());
        chk_b("busy", busy, pos != -1);
        chk_b("frame_done", frame_done, pos == N);
        chk_b("overrun", overrun, m_ov);
        if (frame_done) fd_cnt++;
        if (overrun) ov_cnt++;
        if (busy) begin
            busy_run++;
            busy_cnt++;
        end else if (busy_run != 0) begin
            busy_width = busy_run;
            busy_run = 0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wr(input int l, input int d, input int s, input int v, input int x);
        cfg_lane = 3'(l); cfg_dir = 1'(d); cfg_speed = 4'(s); cfg_div = 4'(v); cfg_x = XW'(x);
        cfg_we = 1'b1;
        cyc(1);
        cfg_we = 1'b0;
    endtask

    task automatic frame();
        int fd0 = fd_cnt;
        int t = 0;
        frame_clk = 1'b1;
        cyc(2);
        frame_clk = 1'b0;
        while (fd_cnt == fd0 && t < 40) begin
            cyc(1);
            t++;
        end
        chk_b("frame_seen", fd_cnt != fd0, 1'b1);
        cyc(2);
    endtask

    task automatic wait_busy();
        int t = 0;
        while (!busy && t < 40) begin
            cyc(1);
            t++;
        end
        chk_b("busy_seen", busy, 1'b1);
    endtask

    initial begin
        int ov0, fd0, b0;
        run = 1'b1;
        cyc(2);
        frame_clk = 1'b1;
        cyc(3);
        frame_clk = 1'b0;
        cyc(10);
        chk_v("reset_lane_x", lane_x, '0);
        chk_b("reset_busy", busy, 1'b0);
        chk_i("reset_frames", fd_cnt, 0);
        Reset_n = 1'b1;
        cyc(2);

        wr(0, 0, 5, 0, 765);
        chk_i("lane0_load", lx(0), 765);
        frame();
        chk_i("right_wrap", lx(0), 2);
        frame();
        chk_i("right_step", lx(0), 7);
        chk_i("frames_2", fd_cnt, 2);

        wr(3, 1, 4, 2, 2);
        frame();
        chk_i("left_div_f1", lx(3), 2);
        frame();
        chk_i("left_div_f2", lx(3), 2);
        frame();
        chk_i("left_wrap_f3", lx(3), 766);
        chk_i("busy_width", busy_width, 9);
        chk_i("frames_5", fd_cnt, 5);
        chk_i("lane0_after5", lx(0), 22);

        wr(2, 0, 3, 0, 50);
        frame_clk = 1'b1;
        wait_busy();
        frame_clk = 1'b0;
        cyc(2);
        wr(2, 0, 3, 0, 100);
        cyc(12);
        chk_i("collision_lane2", lx(2), 100);
        chk_i("collision_lane0", lx(0), 27);

        ov0 = ov_cnt;
        fd0 = fd_cnt;
        frame_clk = 1'b1;
        cyc(1);
        frame_clk = 1'b0;
        cyc(3);
        frame_clk = 1'b1;
        cyc(1);
        frame_clk = 1'b0;
        cyc(20);
        chk_i("overrun_once", ov_cnt - ov0, 1);
        chk_i("overrun_one_frame", fd_cnt - fd0, 1);
        chk_i("overrun_lane0", lx(0), 32);
        chk_i("overrun_lane2", lx(2), 103);

        run = 1'b0;
        b0 = busy_cnt;
        frame_clk = 1'b1;
        cyc(2);
        frame_clk = 1'b0;
        cyc(12);
        chk_i("norun_busy", busy_cnt - b0, 0);
        chk_i("norun_lane0", lx(0), 32);
        chk_i("norun_lane2", lx(2), 103);
        chk_i("norun_lane3", lx(3), 766);

        run = 1'b1;
        frame_clk = 1'b1;
        wait_busy();
        cyc(4);
        Reset_n = 1'b0;
        frame_clk = 1'b0;
        cyc(1);
        chk_v("midreset_lane_x", lane_x, '0);
        chk_b("midreset_busy", busy, 1'b0);
        chk_b("midreset_done", frame_done, 1'b0);
        chk_b("midreset_overrun", overrun, 1'b0);
        Reset_n = 1'b1;
        cyc(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
